// File: rtl/rsa_pkg.sv
// Shared definitions for the response signature analyzer: FSM encoding,
// default MISR constants and the MISR step function.
package rsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } rsa_state_e;

    localparam int unsigned RSA_DATA_W  = 8;
    localparam int unsigned RSA_CNT_W   = 16;
    localparam logic [7:0]  RSA_POLY    = 8'h1D;
    localparam logic [7:0]  RSA_SEED    = 8'h00;
    localparam int unsigned MISR_MAX_W  = 64;

    // One MISR step on the low w bits; callers zero-extend into MISR_MAX_W.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask_v;
        logic                  msb_v;
        mask_v = (64'd1 << w) - 64'd1;
        msb_v  = |(sig & (64'd1 << (w - 32'd1)));
        return (((sig << 1) ^ (msb_v ? poly : 64'd0)) ^ data) & mask_v;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register with seed load and per-beat MISR compaction.
module misr_core
    import rsa_pkg::*;
#(
    parameter int unsigned         DATA_W = RSA_DATA_W,
    parameter logic [DATA_W-1:0]   POLY   = RSA_POLY,
    parameter logic [DATA_W-1:0]   SEED   = RSA_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sig
);

    logic [DATA_W-1:0] sig_r;
    logic [DATA_W-1:0] step_s;

    // Next signature for the current beat.
    always_comb begin
        step_s = DATA_W'(misr_next(64'(sig_r), 64'(data), 64'(POLY), DATA_W));
    end

    // Signature register: load wins over a compaction step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else if (load) begin
            sig_r <= SEED;
        end else if (enable) begin
            sig_r <= step_s;
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/response_signature_analyzer.sv
// Captures a programmed number of DUT output words into a MISR signature and
// compares the result against a golden value.
module response_signature_analyzer
    import rsa_pkg::*;
#(
    parameter int unsigned       DATA_W = RSA_DATA_W,
    parameter int unsigned       CNT_W  = RSA_CNT_W,
    parameter logic [DATA_W-1:0] POLY   = RSA_POLY,
    parameter logic [DATA_W-1:0] SEED   = RSA_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [CNT_W-1:0]  sample_target,
    input  logic [DATA_W-1:0] golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] signature,
    output logic [CNT_W-1:0]  samples_taken
);

    rsa_state_e        state_r;
    rsa_state_e        next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  target_r;
    logic              pass_r;
    logic              load_s;
    logic              step_s;
    logic              pass_clr_s;
    logic              cmp_s;

    misr_core #(
        .DATA_W (DATA_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (reset),
        .load   (load_s),
        .enable (step_s),
        .data   (sample_data),
        .sig    (signature)
    );

    // Next-state and control decode; abort beats start when both are high.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        pass_clr_s   = 1'b0;
        cmp_s        = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    load_s       = 1'b1;
                    pass_clr_s   = 1'b1;
                    next_state_s = (sample_target == {CNT_W{1'b0}}) ? ST_COMPARE : ST_CAPTURE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    pass_clr_s   = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (sample_valid) begin
                    step_s = 1'b1;
                    if ((cnt_r + CNT_W'(1)) == target_r) begin
                        next_state_s = ST_COMPARE;
                    end else begin
                        next_state_s = ST_CAPTURE;
                    end
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_COMPARE: begin
                if (abort) begin
                    pass_clr_s   = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    cmp_s        = 1'b1;
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sample counter and per-run target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            target_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            target_r <= sample_target;
        end else if (step_s) begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    // Verdict register, frozen outside COMPARE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_r <= 1'b0;
        end else if (pass_clr_s) begin
            pass_r <= 1'b0;
        end else if (cmp_s) begin
            pass_r <= (signature == golden_sig);
        end else begin
            pass_r <= pass_r;
        end
    end

    assign busy          = (state_r == ST_CAPTURE) || (state_r == ST_COMPARE);
    assign done          = (state_r == ST_DONE);
    assign pass          = pass_r;
    assign samples_taken = cnt_r;

endmodule

// File: tb/tb_response_signature_analyzer.sv
// Directed-vector bench for response_signature_analyzer with hand-computed
// signatures (POLY=8'h1D, SEED=8'h00).
module tb_response_signature_analyzer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic [15:0] sample_target;
    logic [7:0]  golden_sig;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  signature;
    logic [15:0] samples_taken;

    int total;
    int bad;

    response_signature_analyzer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .sample_target (sample_target),
        .golden_sig    (golden_sig),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature),
        .samples_taken (samples_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        sample_valid  = 1'b0;
        sample_data   = 8'h00;
        sample_target = 16'd0;
        golden_sig    = 8'h00;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig",  32'(signature), 32'h00);
        chk("rst_cnt",  32'(samples_taken), 32'd0);
        reset = 1'b1;
        tick();

        // Basic pass: 01, 80, 00 -> 01, 82, 19
        start = 1'b1; sample_target = 16'd3; golden_sig = 8'h19;
        tick();
        start = 1'b0;
        chk("t1_busy_start", 32'(busy), 32'd1);
        sample_valid = 1'b1; sample_data = 8'h01;
        tick();
        chk("t1_sig1", 32'(signature), 32'h01);
        sample_data = 8'h80;
        tick();
        chk("t1_sig2", 32'(signature), 32'h82);
        sample_data = 8'h00;
        tick();
        sample_valid = 1'b0;
        chk("t1_sig3", 32'(signature), 32'h19);
        chk("t1_cnt", 32'(samples_taken), 32'd3);
        chk("t1_cmp_busy", 32'(busy), 32'd1);
        chk("t1_cmp_done", 32'(done), 32'd0);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        sample_valid = 1'b1; sample_data = 8'hFF;
        tick();
        sample_valid = 1'b0;
        chk("t1_frozen_sig", 32'(signature), 32'h19);
        chk("t1_frozen_done", 32'(done), 32'd1);

        // Fail: same stream, wrong golden, restarted from DONE
        start = 1'b1; golden_sig = 8'h18;
        tick();
        start = 1'b0;
        chk("t2_done_drop", 32'(done), 32'd0);
        chk("t2_sig_seed", 32'(signature), 32'h00);
        chk("t2_pass_clr", 32'(pass), 32'd0);
        sample_valid = 1'b1; sample_data = 8'h01;
        tick();
        sample_data = 8'h80;
        tick();
        sample_data = 8'h00;
        tick();
        sample_valid = 1'b0;
        tick();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_sig", 32'(signature), 32'h19);

        // Gaps between samples
        start = 1'b1; golden_sig = 8'h19;
        tick();
        start = 1'b0;
        sample_valid = 1'b1; sample_data = 8'h01;
        tick();
        sample_valid = 1'b0;
        tick();
        chk("t3_gap_busy_a", 32'(busy), 32'd1);
        tick();
        chk("t3_gap_sig_a", 32'(signature), 32'h01);
        sample_valid = 1'b1; sample_data = 8'h80;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        chk("t3_gap_busy_b", 32'(busy), 32'd1);
        chk("t3_gap_sig_b", 32'(signature), 32'h82);
        chk("t3_gap_cnt_b", 32'(samples_taken), 32'd2);
        sample_valid = 1'b1; sample_data = 8'h00;
        tick();
        sample_valid = 1'b0;
        chk("t3_cmp_busy", 32'(busy), 32'd1);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_pass", 32'(pass), 32'd1);
        chk("t3_sig", 32'(signature), 32'h19);

        // Zero target: straight to COMPARE, beats ignored
        start = 1'b1; sample_target = 16'd0; golden_sig = 8'h00;
        sample_valid = 1'b1; sample_data = 8'h5A;
        tick();
        start = 1'b0;
        chk("t4_cmp_busy", 32'(busy), 32'd1);
        chk("t4_cmp_sig", 32'(signature), 32'h00);
        tick();
        sample_valid = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_pass", 32'(pass), 32'd1);
        chk("t4_cnt", 32'(samples_taken), 32'd0);
        chk("t4_sig", 32'(signature), 32'h00);

        // Abort mid-capture, then start+abort together in IDLE
        start = 1'b1; sample_target = 16'd3; golden_sig = 8'h19;
        tick();
        start = 1'b0;
        sample_valid = 1'b1; sample_data = 8'h01;
        tick();
        sample_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_done", 32'(done), 32'd0);
        chk("t5_abort_pass", 32'(pass), 32'd0);
        chk("t5_abort_sig", 32'(signature), 32'h01);
        chk("t5_abort_cnt", 32'(samples_taken), 32'd1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_prio_busy", 32'(busy), 32'd0);
        chk("t5_prio_sig", 32'(signature), 32'h01);
        tick();
        chk("t5_prio_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-run
        start = 1'b1; sample_target = 16'd5;
        tick();
        start = 1'b0;
        sample_valid = 1'b1; sample_data = 8'h01;
        tick();
        sample_data = 8'h80;
        tick();
        sample_valid = 1'b0;
        chk("t6_pre_cnt", 32'(samples_taken), 32'd2);
        chk("t6_pre_sig", 32'(signature), 32'h82);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_sig", 32'(signature), 32'h00);
        chk("t6_async_cnt", 32'(samples_taken), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        start = 1'b1; sample_target = 16'd1; golden_sig = 8'hA5;
        tick();
        start = 1'b0;
        sample_valid = 1'b1; sample_data = 8'hA5;
        tick();
        sample_valid = 1'b0;
        chk("t6_sig", 32'(signature), 32'hA5);
        tick();
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_pass", 32'(pass), 32'd1);
        chk("t6_cnt", 32'(samples_taken), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
